// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// opcode field position, PC increment and the default reset PC.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } ifu_state_e;

  localparam int          IFU_OPC_HI           = 31;
  localparam int          IFU_OPC_LO           = 26;
  localparam logic [31:0] IFU_PC_INC           = 32'd4;
  localparam logic [31:0] IFU_DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifu_instr_fifo.sv
// Instruction buffer: DEPTH entries of {instr, fetch addr}, synchronous clear,
// push and pop allowed in the same cycle even when full.
module ifu_instr_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_pop, do_push;

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != DEPTH_C) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage is data only; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-outstanding fetch FSM, fetch PC and redirect
// handling. Optional macro IFU_ALIGN_CHECK_EN adds the fetch_misalign output.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IFU_DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] ctrl_in_address,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instrn,
  output logic [5:0]  instrn_opcode,
  output logic [31:0] address_plus_4
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  ifu_state_e       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      addr_q, addr_d;
  logic             pend_q, pend_d;
  logic [31:0]      target;
  logic             can_req;
  logic             push, pop_fire, fifo_empty, go_req;
  logic [CNT_W-1:0] cnt, cnt_eff;
  logic [63:0]      head;

`ifdef IFU_ALIGN_CHECK_EN
  logic mis_q, mis_set;
  assign target         = ctrl_in_address;
  assign mis_set        = redirect_valid && (ctrl_in_address[1:0] != 2'b00);
  assign can_req        = !(mis_q || mis_set);
  assign fetch_misalign = mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mis_q <= 1'b0;
    else if (mis_set) mis_q <= 1'b1;
  end
`else
  logic unused_addr_lsb;
  assign target          = {ctrl_in_address[31:2], 2'b00};
  assign unused_addr_lsb = ^ctrl_in_address[1:0];
  assign can_req         = 1'b1;
`endif

  assign pop_fire = instr_ready && !fifo_empty;
  assign push     = (state_q == WAIT) && imem_rvalid && !redirect_valid;
  // Occupancy as seen after this edge; a redirect empties the buffer
  assign cnt_eff  = redirect_valid ? '0 : cnt + CNT_W'(push) - CNT_W'(pop_fire);
  assign go_req   = can_req && (cnt_eff < DEPTH_C);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    if (redirect_valid) pc_d = target;
    else if (push)      pc_d = pc_q + IFU_PC_INC;
    case (state_q)
      IDLE: if (go_req) state_d = REQ;
      REQ: begin
        if (redirect_valid) pend_d = 1'b1;
        if (imem_gnt) begin
          state_d = (pend_q || redirect_valid) ? DROP : WAIT;
          pend_d  = 1'b0;
        end
      end
      WAIT: begin
        if (imem_rvalid)         state_d = go_req ? REQ : IDLE;
        else if (redirect_valid) state_d = DROP;
      end
      DROP: if (imem_rvalid) state_d = go_req ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
    if ((state_d == REQ) && (state_q != REQ)) addr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
    end
  end

  ifu_instr_fifo #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (64)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (redirect_valid),
    .push      (push),
    .push_data ({imem_rdata, addr_q}),
    .pop       (pop_fire),
    .head_data (head),
    .empty     (fifo_empty),
    .count     (cnt)
  );

  // Head outputs are zero while the buffer is empty
  assign imem_req       = (state_q == REQ);
  assign imem_addr      = addr_q;
  assign instr_valid    = !fifo_empty;
  assign instrn         = fifo_empty ? '0 : head[63:32];
  assign instrn_opcode  = instrn[IFU_OPC_HI:IFU_OPC_LO];
  assign address_plus_4 = fifo_empty ? '0 : head[31:0] + IFU_PC_INC;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (default BUF_DEPTH=2, RESET_PC=0);
// the misalign scenario is exercised when IFU_ALIGN_CHECK_EN is defined.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] ctrl_in_address;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instrn;
  logic [5:0]  instrn_opcode;
  logic [31:0] address_plus_4;
`ifdef IFU_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .ctrl_in_address (ctrl_in_address),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instrn          (instrn),
    .instrn_opcode   (instrn_opcode),
    .address_plus_4  (address_plus_4)
`ifdef IFU_ALIGN_CHECK_EN
    ,
    .fetch_misalign  (fetch_misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; ctrl_in_address = '0; instr_ready = 1'b0;
    step(); step();
    chk("rst_req",    imem_req, 0);
    chk("rst_addr",   imem_addr, 0);
    chk("rst_valid",  instr_valid, 0);
    chk("rst_instrn", instrn, 0);
    chk("rst_opc",    instrn_opcode, 0);
    chk("rst_ap4",    address_plus_4, 0);

    // First fetch after reset release
    rst_n = 1'b1;
    step();
    chk("first_req",  imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    chk("wait_noreq", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h8C22_0004; step(); imem_rvalid = 1'b0;
    chk("f0_valid",  instr_valid, 1);
    chk("f0_instrn", instrn, 32'h8C22_0004);
    chk("f0_opc",    instrn_opcode, 6'h23);
    chk("f0_ap4",    address_plus_4, 32'h4);
    chk("b2b_req",   imem_req, 1);
    chk("b2b_addr",  imem_addr, 32'h4);

    // Fill the buffer with no downstream pops
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; step(); imem_rvalid = 1'b0;
    chk("full_noreq", imem_req, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_req", imem_req, 0);
    end
    chk("full_head", instrn, 32'h8C22_0004);
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    chk("pop_instrn", instrn, 32'h1111_1111);
    chk("pop_ap4",    address_plus_4, 32'h8);
    chk("pop_req",    imem_req, 1);
    chk("pop_addr",   imem_addr, 32'h8);

    // Redirect while waiting for the addr-8 response
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    redirect_valid = 1'b1; ctrl_in_address = 32'h40; step(); redirect_valid = 1'b0;
    chk("rw_valid", instr_valid, 0);
    chk("rw_req",   imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(); imem_rvalid = 1'b0;
    chk("rw_drop_valid", instr_valid, 0);
    chk("rw_req2",  imem_req, 1);
    chk("rw_addr2", imem_addr, 32'h40);
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0040; step(); imem_rvalid = 1'b0;
    chk("t40_instrn", instrn, 32'hAAAA_0040);
    chk("t40_ap4",    address_plus_4, 32'h44);
    chk("t40_addr",   imem_addr, 32'h44);

    // Redirect while the 0x44 request is still ungranted
    redirect_valid = 1'b1; ctrl_in_address = 32'h100; step(); redirect_valid = 1'b0;
    chk("ru_req",   imem_req, 1);
    chk("ru_addr",  imem_addr, 32'h44);
    chk("ru_valid", instr_valid, 0);
    step(); step();
    chk("ru_hold_req",  imem_req, 1);
    chk("ru_hold_addr", imem_addr, 32'h44);
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    chk("ru_drop_req", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0044; step(); imem_rvalid = 1'b0;
    chk("ru_valid2", instr_valid, 0);
    chk("ru_req2",   imem_req, 1);
    chk("ru_addr2",  imem_addr, 32'h100);

    // Redirect coincident with rvalid and a pop
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0100; step(); imem_rvalid = 1'b0;
    chk("c_head", instrn, 32'hCAFE_0100);
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0104;
    redirect_valid = 1'b1; ctrl_in_address = 32'h200; instr_ready = 1'b1;
    step();
    imem_rvalid = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    chk("c_valid",  instr_valid, 0);
    chk("c_instrn", instrn, 0);
    chk("c_req",    imem_req, 1);
    chk("c_addr",   imem_addr, 32'h200);
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; step(); imem_rvalid = 1'b0;
    chk("c_new_instrn", instrn, 32'h1234_5678);
    chk("c_new_ap4",    address_plus_4, 32'h204);

    // Misaligned redirect target while waiting for 0x204
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    redirect_valid = 1'b1; ctrl_in_address = 32'h42; step(); redirect_valid = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0204; step(); imem_rvalid = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    chk("mis_flag", fetch_misalign, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mis_noreq", imem_req, 0);
    end
    chk("mis_sticky", fetch_misalign, 1);
`else
    chk("lsb_req",  imem_req, 1);
    chk("lsb_addr", imem_addr, 32'h40);
`endif

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   imem_req, 0);
    chk("arst_addr",  imem_addr, 0);
    chk("arst_valid", instr_valid, 0);
`ifdef IFU_ALIGN_CHECK_EN
    chk("arst_mis",   fetch_misalign, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req / imem_addr  output  1 / 32  fetch request and its word address.
REQ-006 imem_gnt  input  1  memory accepts the request this cycle.
REQ-007 imem_rvalid / imem_rdata  input  1 / 32  read response, at least 1 cycle after grant.
REQ-008 redirect_valid / ctrl_in_address  input  1 / 32  one-cycle pulse carrying a non-sequential next PC (branch or jump target).
REQ-009 instr_valid / instr_ready  output / input  1 / 1  downstream instruction handshake.
REQ-010 instrn / instrn_opcode / address_plus_4  output  32 / 6 / 32  buffer-head instruction, its bits [31:26], and its fetch address + 4.

Function
REQ-011 FSM states: IDLE, REQ, WAIT, DROP; at most one request outstanding.
REQ-012 IDLE -> REQ when (buffer count + outstanding) < BUF_DEPTH; imem_addr is latched from the fetch PC on entry to REQ.
REQ-013 In REQ, imem_req SHALL be 1 and imem_addr SHALL be held stable until imem_gnt; on grant go to WAIT, or go to DROP if a redirect is pending.
REQ-014 WAIT: on imem_rvalid, push {imem_rdata, imem_addr} into the buffer, set fetch PC += 4 (32-bit wrap), then go to REQ if space remains, else IDLE.
REQ-015 DROP: on imem_rvalid, discard the data and go to REQ if space remains, else IDLE.
REQ-016 redirect_valid: in the same edge, set fetch PC = ctrl_in_address, clear the buffer, and set instr_valid = 0 next cycle.
REQ-017 Redirect while WAIT without rvalid: go to DROP. Redirect coincident with rvalid: discard the response.
REQ-018 Redirect while REQ not yet granted: the request completes at its old address and the response is dropped.
REQ-019 instr_valid = buffer not empty; pop on instr_valid && instr_ready. Outputs come from registered buffer head; no combinational path from imem_rdata.
REQ-020 Push and pop in the same cycle SHALL both take effect, including when the buffer is full.
REQ-021 Pop coincident with redirect: the pop is accepted, and the buffer is still fully cleared.
REQ-022 Back-to-back fetch: a new request SHALL be issued the cycle after rvalid when space remains.

Reset
REQ-023 On rst_n low: imem_req=0, imem_addr=0, instr_valid=0, instrn=0, instrn_opcode=0, address_plus_4=0, buffer empty, FSM=IDLE, fetch PC=RESET_PC, redirect-pending=0.
REQ-024 Reset mid-transaction abandons any outstanding request. First imem_req SHALL assert in the cycle after rst_n is sampled high.

Configuration
REQ-025 Macro IFU_ALIGN_CHECK_EN defined: add output fetch_misalign (1 bit). A redirect with ctrl_in_address[1:0] != 0 sets fetch_misalign sticky until reset and stops all new requests; any outstanding response is still drained.
REQ-026 IFU_ALIGN_CHECK_EN undefined: no fetch_misalign port; ctrl_in_address[1:0] is forced to 0.

Structure
REQ-027 The shared package SHALL hold the FSM state enum, the opcode field position (31:26), the PC increment constant 4, and the default RESET_PC.
REQ-028 One sub-module, ifu_instr_fifo (BUF_DEPTH x 64-bit, synchronous clear, simultaneous push and pop), SHALL hold the buffer; the FSM and PC stay in instr_fetch_unit.

Verification
REQ-029 Reset release, grant immediate, rvalid 1 cycle later, rdata=32'h8C22_0004 -> imem_addr=0, then instrn=32'h8C22_0004, opcode=6'h23, address_plus_4=4.
REQ-030 instr_ready=0 with BUF_DEPTH=2 -> exactly 2 words fetched (addr 0, 4), then imem_req stays 0 until a pop.
REQ-031 Redirect to 32'h0000_0040 while WAIT at addr 8 -> the addr-8 response is dropped and the next imem_addr=32'h40.
REQ-032 Redirect while REQ ungranted at addr 8, grant 3 cycles later -> imem_addr stays 8 until grant, the response is dropped, and the next request goes to the target.
REQ-033 Redirect coincident with rvalid and a pop -> buffer empty, instr_valid=0 next cycle, and no instruction from the old stream is delivered afterward.
REQ-034 With IFU_ALIGN_CHECK_EN, redirect to 32'h0000_0042 -> fetch_misalign=1 and no further imem_req until reset.
